// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the registered stream multiplexer.
package stream_mux_pkg;

    localparam int unsigned N_CH_DEF = 4;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

    typedef logic [clog2_min1(N_CH_DEF)-1:0] ch_idx_t;

endpackage

// File: rtl/stream_mux_reg_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, wrapping.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_CH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [N_CH-1:0] grant_c
);

    localparam int unsigned PTR_W = clog2_min1(N_CH);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] gidx_c;
    logic             found_c;
    int unsigned      dist_c;
    int unsigned      best_c;

    // Pick the requester with the smallest rotational distance from the pointer.
    always_comb begin
        gidx_c  = '0;
        found_c = 1'b0;
        dist_c  = 0;
        best_c  = N_CH;
        grant_c = '0;
        ptr_d   = ptr_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            dist_c = (i + N_CH - 32'(ptr_q)) % N_CH;
            if (req[i] && (dist_c < best_c)) begin
                best_c  = dist_c;
                gidx_c  = PTR_W'(i);
                found_c = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            grant_c[i] = found_c && (gidx_c == PTR_W'(i));
        end
        if (advance && found_c) begin
            ptr_d = (gidx_c == PTR_W'(N_CH - 1)) ? '0 : gidx_c + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_reg.sv
// Registered N:1 valid/ready stream mux; fixed sel by default, round-robin
// arbitration when STREAM_MUX_REG_RR_EN is defined.
module stream_mux_reg
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic [$clog2(N_CH)-1:0] sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [$clog2(N_CH)-1:0] out_ch,
    input  logic                    out_ready
);

    localparam int unsigned SEL_W = $clog2(N_CH);

    logic             load_en_c;
    logic             xfer_c;
    logic [N_CH-1:0]  grant_c;

    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [SEL_W-1:0] out_ch_q;
    logic [SEL_W-1:0] out_ch_d;

`ifdef STREAM_MUX_REG_RR_EN
    logic unused_sel_c;
    assign unused_sel_c = ^sel;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (xfer_c),
        .grant_c (grant_c)
    );
`else
    // Out-of-range select matches no channel, so nothing is granted.
    always_comb begin
        grant_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            grant_c[i] = (sel == SEL_W'(i));
        end
    end
`endif

    assign load_en_c = !out_valid_q || out_ready;
    assign in_ready  = load_en_c ? grant_c : '0;
    assign xfer_c    = |(in_valid & in_ready);

    // Output register: hold on stall, otherwise load the granted beat or go idle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (load_en_c) begin
            out_valid_d = xfer_c;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (grant_c[i] && in_valid[i]) begin
                    out_data_d = in_data[i*WIDTH +: WIDTH];
                    out_ch_d   = SEL_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_reg.sv
// Directed bench for stream_mux_reg with a scoreboard of expected output beats.
module tb_stream_mux_reg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned WIDTH = 8;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;
    int   mptr;

    stream_mux_reg #(.N_CH(N_CH), .WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    stream_mux_reg #(.N_CH(3), .WIDTH(WIDTH)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ch    (out_ch3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] v);
        in_data[ch*8 +: 8] = v;
    endtask

    // Scoreboard monitor: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        bit         g_ok;
        int         g;
        bit         load_en;
        logic [3:0] exp_ready;
        exp_t       e;
        if (rst) begin
            sb_q.delete();
            mptr = 0;
        end else begin
            g_ok = 1'b0;
            g    = 0;
`ifdef STREAM_MUX_REG_RR_EN
            for (int k = 0; k < int'(N_CH); k++) begin
                int idx;
                idx = (mptr + k) % int'(N_CH);
                if (!g_ok && in_valid[idx]) begin
                    g_ok = 1'b1;
                    g    = idx;
                end
            end
`else
            if (int'(sel) < int'(N_CH)) begin
                g_ok = 1'b1;
                g    = int'(sel);
            end
`endif
            load_en   = !out_valid || out_ready;
            exp_ready = (g_ok && load_en) ? (4'b0001 << g) : 4'b0000;
            chk("mon_in_ready", 32'(in_ready), 32'(exp_ready));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.data));
                    chk("sb_ch", 32'(out_ch), 32'(e.ch));
                end
            end
            if (g_ok && load_en && in_valid[g]) begin
                e.ch   = 2'(g);
                e.data = in_data[g*8 +: 8];
                sb_q.push_back(e);
`ifdef STREAM_MUX_REG_RR_EN
                mptr = (g + 1) % int'(N_CH);
`endif
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        mptr       = 0;
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = '0;
        sel        = '0;
        out_ready  = 1'b1;
        in_data3   = '0;
        in_valid3  = '0;
        sel3       = '0;
        out_ready3 = 1'b1;

        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        rst = 1'b0;
        tick();

`ifdef STREAM_MUX_REG_RR_EN
        for (int i = 0; i < 4; i++) set_ch(i, 8'(8'h10 + i));
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_all_out_ch", 32'(out_ch), 32'(k % 4));
            chk("rr_all_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 4'b1010;
        tick();
        chk("rr_sparse_g0", 32'(out_ch), 32'd1);
        tick();
        chk("rr_sparse_g1", 32'(out_ch), 32'd3);
        tick();
        chk("rr_sparse_g2", 32'(out_ch), 32'd1);
        chk("rr_sparse_data", 32'(out_data), 32'h11);
        in_valid = 4'b0000;
        tick();
        chk("rr_idle_valid", 32'(out_valid), 32'd0);
`else
        // Fixed select on channel 2.
        sel = 2'd2;
        set_ch(2, 8'h3C);
        in_valid = 4'b0100;
        #1;
        chk("fix_in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("fix_out_data", 32'(out_data), 32'h3C);
        chk("fix_out_ch", 32'(out_ch), 32'd2);
        chk("fix_out_valid", 32'(out_valid), 32'd1);

        // Stall with select change underneath the held beat.
        out_ready = 1'b0;
        sel = 2'd1;
        set_ch(1, 8'h5A);
        in_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("stall_out_data", 32'(out_data), 32'h3C);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_ch", 32'(out_ch), 32'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("release_out_data", 32'(out_data), 32'h5A);
        chk("release_out_ch", 32'(out_ch), 32'd1);
        in_valid = 4'b0000;
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_data_held", 32'(out_data), 32'h5A);

        // Back-to-back beats on channel 0.
        sel = 2'd0;
        in_valid = 4'b0001;
        for (int d = 1; d <= 4; d++) begin
            set_ch(0, 8'(d));
            tick();
            chk("b2b_out_data", 32'(out_data), 32'(d));
            chk("b2b_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 4'b0000;
        tick();
        chk("b2b_drain_valid", 32'(out_valid), 32'd0);

        // Invalid select on the 3-channel instance.
        in_data3  = 24'h33_22_11;
        sel3      = 2'd0;
        in_valid3 = 3'b111;
        tick();
        chk("inv_pre_valid", 32'(out_valid3), 32'd1);
        chk("inv_pre_data", 32'(out_data3), 32'h11);
        sel3 = 2'd3;
        #1;
        chk("inv_in_ready", 32'(in_ready3), 32'd0);
        tick();
        chk("inv_drain_valid", 32'(out_valid3), 32'd0);
        chk("inv_in_ready_idle", 32'(in_ready3), 32'd0);
        in_valid3 = 3'b000;
`endif

        // Reset while a beat is held on the output.
        sel = 2'd0;
        set_ch(0, 8'hA5);
        in_valid = 4'b1111;
        tick();
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        chk("mid_pre_data", 32'(out_data), 32'hA5);
        in_valid = 4'b0000;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_ch", 32'(out_ch), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
